// File: rtl/nn_pkg.sv
// Shared types and helpers for the fixed-point NN blocks.
// Provides: seq_state_e (sequencer FSM states), acc_t/data_t, sat_q().
package nn_pkg;

    localparam int NN_WIDTH = 16;
    localparam int NN_FRAC  = 8;
    localparam int NN_ACC_W = 40;

    typedef logic signed [NN_ACC_W-1:0] acc_t;
    typedef logic signed [NN_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_RESULT,
        S_OUT,
        S_FINISH
    } seq_state_e;

    // Clamp a to the signed range of a width-bit word.
    function automatic acc_t sat_q(input acc_t a, input int width);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (width - 1)) - acc_t'(1);
        lo = ~hi;
        if (a > hi) return hi;
        if (a < lo) return lo;
        return a;
    endfunction

endpackage

// File: rtl/nn_requant.sv
// Combinational requantiser: bias add, arithmetic shift, saturate, ReLU.
// Ports: acc (accumulator), bias (Q.FRAC), relu (enable), res (result).
module nn_requant
    import nn_pkg::*;
#(
    parameter int WIDTH = NN_WIDTH,
    parameter int FRAC  = NN_FRAC,
    parameter int ACC_W = NN_ACC_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [WIDTH-1:0] bias,
    input  logic             relu,
    output logic [WIDTH-1:0] res
);

    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    acc_t                    sat;

    always_comb begin
        bias_ext = {{(ACC_W-WIDTH){bias[WIDTH-1]}}, bias};
        sum      = $signed(acc) + (bias_ext <<< FRAC);
        // Arithmetic shift: rounds toward -inf.
        shifted  = sum >>> FRAC;
        sat      = sat_q(acc_t'(shifted), WIDTH);
        if (relu && sat < 0) begin
            res = '0;
        end else begin
            res = sat[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/dense_layer_sequencer.sv
// Time-multiplexed dense layer controller: y = W*x + b, optional ReLU.
// Ports: start/cfg_* in, busy/done/cfg_err status, rd_* memory reads,
// x/w/b_data read returns (1-cycle latency), out_* valid/ready stream.
module dense_layer_sequencer
    import nn_pkg::*;
#(
    parameter int BATCH = 15,
    parameter int MAX_M = 64,
    parameter int MAX_N = 64,
    parameter int WIDTH = NN_WIDTH,
    parameter int FRAC  = NN_FRAC,
    parameter int ACC_W = NN_ACC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(MAX_M+1)-1:0] cfg_m,
    input  logic [$clog2(MAX_N+1)-1:0] cfg_n,
    input  logic                       cfg_relu,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err,
    output logic                       rd_en,
    output logic [$clog2(BATCH)-1:0]   rd_b,
    output logic [$clog2(MAX_M)-1:0]   rd_m,
    output logic [$clog2(MAX_N)-1:0]   rd_n,
    input  logic [WIDTH-1:0]           x_data,
    input  logic [WIDTH-1:0]           w_data,
    input  logic [WIDTH-1:0]           b_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(BATCH)-1:0]   out_b,
    output logic [$clog2(MAX_M)-1:0]   out_m,
    output logic [WIDTH-1:0]           out_data
);

    localparam int MW = $clog2(MAX_M+1);
    localparam int NW = $clog2(MAX_N+1);
    localparam int BW = $clog2(BATCH);
    localparam int MI = $clog2(MAX_M);
    localparam int NI = $clog2(MAX_N);

    localparam logic [MW-1:0] MAX_M_V = MW'(MAX_M);
    localparam logic [NW-1:0] MAX_N_V = NW'(MAX_N);
    localparam logic [BW-1:0] LAST_B  = BW'(BATCH-1);

    seq_state_e state, nxt;

    logic [MW-1:0]    m_cfg;
    logic [NW-1:0]    n_cfg;
    logic             relu_q;
    logic             err_q;
    logic [BW-1:0]    b_idx;
    logic [MI-1:0]    m_idx;
    logic [NI-1:0]    n_idx;
    logic             v_q;
    logic             first_q;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] bias_q;
    logic [WIDTH-1:0] req;

    logic                    cfg_bad;
    logic                    last_n;
    logic                    last_m;
    logic                    last_b;
    logic signed [2*WIDTH-1:0] prod;
    logic [ACC_W-1:0]        prod_ext;

    assign cfg_bad = (cfg_m == '0) || (cfg_n == '0) ||
                     (cfg_m > MAX_M_V) || (cfg_n > MAX_N_V);
    assign last_n  = (NW'(n_idx) == n_cfg - NW'(1));
    assign last_m  = (MW'(m_idx) == m_cfg - MW'(1));
    assign last_b  = (b_idx == LAST_B);

    assign prod     = $signed(x_data) * $signed(w_data);
    assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};

    assign rd_b = b_idx;
    assign rd_m = m_idx;
    assign rd_n = n_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt     = state;
        busy    = 1'b0;
        done    = 1'b0;
        cfg_err = 1'b0;
        rd_en   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    nxt = cfg_bad ? S_FINISH : S_MAC;
                end
            end
            S_MAC: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (last_n) begin
                    nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                nxt  = S_RESULT;
            end
            S_RESULT: begin
                busy = 1'b1;
                nxt  = S_OUT;
            end
            S_OUT: begin
                busy = 1'b1;
                if (out_ready) begin
                    nxt = (last_m && last_b) ? S_FINISH : S_MAC;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                cfg_err = err_q;
                nxt     = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Config latch and b/m/n index counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cfg  <= '0;
            n_cfg  <= '0;
            relu_q <= 1'b0;
            err_q  <= 1'b0;
            b_idx  <= '0;
            m_idx  <= '0;
            n_idx  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        m_cfg  <= cfg_m;
                        n_cfg  <= cfg_n;
                        relu_q <= cfg_relu;
                        err_q  <= cfg_bad;
                        b_idx  <= '0;
                        m_idx  <= '0;
                        n_idx  <= '0;
                    end
                end
                S_MAC: begin
                    n_idx <= last_n ? '0 : n_idx + NI'(1);
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (last_m) begin
                            m_idx <= '0;
                            if (!last_b) begin
                                b_idx <= b_idx + BW'(1);
                            end
                        end else begin
                            m_idx <= m_idx + MI'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Read-valid pipe and accumulator; first product replaces acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= 1'b0;
            first_q <= 1'b0;
            acc     <= '0;
            bias_q  <= '0;
        end else begin
            v_q     <= (state == S_MAC);
            first_q <= (state == S_MAC) && (n_idx == '0);
            if (v_q) begin
                acc <= first_q ? prod_ext : acc + prod_ext;
                if (first_q) begin
                    bias_q <= b_data;
                end
            end
        end
    end

    nn_requant #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_req (
        .acc  (acc),
        .bias (bias_q),
        .relu (relu_q),
        .res  (req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_b     <= '0;
            out_m     <= '0;
            out_data  <= '0;
        end else begin
            if (state == S_RESULT) begin
                out_valid <= 1'b1;
                out_b     <= b_idx;
                out_m     <= m_idx;
                out_data  <= req;
            end else if (state == S_OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Directed bench for dense_layer_sequencer with memory and golden models.
// Ports: none; drives and samples the DUT on the falling clock edge.
module tb_dense_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  cfg_m;
    logic [6:0]  cfg_n;
    logic        cfg_relu;
    logic        busy, done, cfg_err, rd_en;
    logic [3:0]  rd_b;
    logic [5:0]  rd_m, rd_n;
    logic [15:0] x_data, w_data, b_data;
    logic        out_valid, out_ready;
    logic [3:0]  out_b;
    logic [5:0]  out_m;
    logic [15:0] out_data;

    logic signed [15:0] xm [15][64];
    logic signed [15:0] wm [64][64];
    logic signed [15:0] bm [64];

    int total = 0;
    int fails = 0;
    int q_b[$];
    int q_m[$];
    logic [15:0] q_d[$];
    int last_hs;

    always #5 clk = ~clk;

    dense_layer_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_m     (cfg_m),
        .cfg_n     (cfg_n),
        .cfg_relu  (cfg_relu),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .rd_en     (rd_en),
        .rd_b      (rd_b),
        .rd_m      (rd_m),
        .rd_n      (rd_n),
        .x_data    (x_data),
        .w_data    (w_data),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_m     (out_m),
        .out_data  (out_data)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            x_data <= xm[rd_b][rd_n];
            w_data <= wm[rd_m][rd_n];
            b_data <= bm[rd_m];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] golden(int b, int m, int n, bit relu);
        longint a;
        a = 0;
        for (int i = 0; i < n; i++) begin
            a += longint'(xm[b][i]) * longint'(wm[m][i]);
        end
        a = (a + (longint'(bm[m]) <<< 8)) >>> 8;
        if (a > 32767) a = 32767;
        if (a < -32768) a = -32768;
        if (relu && a < 0) a = 0;
        return a[15:0];
    endfunction

    task automatic load_t1();
        for (int b = 0; b < 15; b++) begin
            xm[b][0] = 16'sd256;
            xm[b][1] = 16'sd512;
        end
        wm[0][0] = 16'sd128;
        wm[0][1] = 16'sd64;
        bm[0]    = 16'sd64;
    endtask

    task automatic start_run(input int m, input int n, input bit relu);
        q_b.delete();
        q_m.delete();
        q_d.delete();
        last_hs  = 0;
        cfg_m    = 7'(m);
        cfg_n    = 7'(n);
        cfg_relu = relu;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Cycle numbering: start cycle is 1; returns cycle where done is seen.
    task automatic collect(input int first, input int maxcyc, output int cyc);
        cyc = first;
        while (!done && cyc < maxcyc) begin
            if (out_valid && out_ready) begin
                q_b.push_back(int'(out_b));
                q_m.push_back(int'(out_m));
                q_d.push_back(out_data);
                last_hs = cyc;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int k;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_m     = '0;
        cfg_n     = '0;
        cfg_relu  = 1'b0;
        out_ready = 1'b1;
        for (int b = 0; b < 15; b++)
            for (int i = 0; i < 64; i++) xm[b][i] = '0;
        for (int m = 0; m < 64; m++) begin
            bm[m] = '0;
            for (int i = 0; i < 64; i++) wm[m][i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rden", rd_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // T1 basic
        load_t1();
        start_run(1, 2, 0);
        chk("t1_busy", busy, 1);
        collect(2, 200, cyc);
        chk("t1_done", done, 1);
        chk("t1_err", cfg_err, 0);
        chk("t1_nbusy", busy, 0);
        chk("t1_cycles", cyc, 2 + 15 * 5);
        chk("t1_count", q_d.size(), 15);
        chk("t1_data", q_d[0], 16'd320);
        chk("t1_b", q_b[0], 0);
        chk("t1_m", q_m[0], 0);
        chk("t1_lastb", q_b[14], 14);
        chk("t1_doneafter", cyc, last_hs + 1);
        @(negedge clk);

        // T2 saturation
        for (int b = 0; b < 15; b++) begin
            xm[b][0] = 16'sd32767;
            xm[b][1] = 16'sd32767;
        end
        wm[0][0] = 16'sd32767;
        wm[0][1] = 16'sd32767;
        bm[0]    = '0;
        start_run(1, 2, 0);
        collect(2, 200, cyc);
        chk("t2_sat", q_d[0], 16'h7fff);
        @(negedge clk);
        wm[0][0] = '0;
        wm[0][1] = '0;
        bm[0]    = -16'sd256;
        start_run(1, 2, 1);
        collect(2, 200, cyc);
        chk("t2_relu1", q_d[0], 16'h0000);
        @(negedge clk);
        start_run(1, 2, 0);
        collect(2, 200, cyc);
        chk("t2_relu0", q_d[0], 16'hff00);
        @(negedge clk);

        // T3 backpressure on the first result
        load_t1();
        out_ready = 1'b0;
        start_run(1, 2, 0);
        k = 2;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t3_valid_seen", out_valid, 1);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("t3_valid", out_valid, 1);
            chk("t3_data", out_data, 16'd320);
            chk("t3_ob", out_b, 0);
            chk("t3_om", out_m, 0);
            chk("t3_rden", rd_en, 0);
            chk("t3_rdm", rd_m, 0);
            chk("t3_rdb", rd_b, 0);
        end
        out_ready = 1'b1;
        collect(k + 5, 300, cyc);
        chk("t3_done", done, 1);
        chk("t3_count", q_d.size(), 15);
        chk("t3_cycles", cyc, 2 + 15 * 5 + 5);
        @(negedge clk);

        // T4 full layer with random operands
        for (int b = 0; b < 15; b++)
            for (int i = 0; i < 64; i++) xm[b][i] = 16'($urandom());
        for (int m = 0; m < 3; m++) begin
            bm[m] = 16'($urandom_range(0, 4095)) - 16'sd2048;
            for (int i = 0; i < 64; i++) wm[m][i] = 16'($urandom_range(0, 511)) - 16'sd256;
        end
        start_run(3, 64, 1);
        collect(2, 4000, cyc);
        chk("t4_cycles", cyc, 2 + 45 * 67);
        chk("t4_count", q_d.size(), 45);
        for (int j = 0; j < 45; j++) begin
            if (j < q_d.size()) begin
                chk("t4_b", q_b[j], j / 3);
                chk("t4_m", q_m[j], j % 3);
                chk("t4_data", q_d[j], golden(j / 3, j % 3, 64, 1));
            end
        end
        @(negedge clk);

        // T5 config errors and ignored start
        start_run(1, 0, 0);
        chk("t5_done", done, 1);
        chk("t5_err", cfg_err, 1);
        chk("t5_rden", rd_en, 0);
        chk("t5_valid", out_valid, 0);
        @(negedge clk);
        chk("t5_idle", done, 0);
        start_run(65, 2, 0);
        chk("t5_m65_err", cfg_err, 1);
        @(negedge clk);
        load_t1();
        start_run(1, 2, 0);
        cfg_n = 7'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(3, 200, cyc);
        chk("t5_ign_cycles", cyc, 2 + 15 * 5);
        chk("t5_ign_count", q_d.size(), 15);
        chk("t5_ign_err", cfg_err, 0);
        @(negedge clk);

        // T6 reset during MAC of neuron 10
        start_run(16, 4, 0);
        k = 2;
        while (!(rd_en && rd_m == 6'd10) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("t6_reach", k < 400, 1);
        rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_rden", rd_en, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_rdm", rd_m, 0);
        chk("t6_data", out_data, 0);
        k = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) k++;
        end
        chk("t6_nodone", k, 0);
        rst = 1'b0;
        @(negedge clk);
        load_t1();
        start_run(1, 2, 0);
        collect(2, 200, cyc);
        chk("t6_rerun_cyc", cyc, 2 + 15 * 5);
        chk("t6_rerun_data", q_d[0], 16'd320);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
